// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: 8N1 UART command parser that performs single-byte writes ('W' addr data)
// and reads ('R' addr) on a data memory and answers each command with one response byte.
module uart_mem_bridge #(
   parameter int CLKS_PER_BIT = 16,
   parameter int TIMEOUT_CLKS = 4096
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       rx,
   output logic       tx,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_w_data,
   output logic       mem_w_en,
   output logic       mem_r_en,
   input  logic [7:0] mem_r_data,
   output logic       busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CLKS - 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, EXEC_W, EXEC_R, RESPOND} state_t;

   rx_state_t     rx_st;
   state_t        state, next;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] rx_cnt, tx_cnt;
   logic [2:0]    rx_bits;
   logic [7:0]    rx_shift, resp;
   logic          rx_done, op_w, waiting, to_hit, tx_active, tx_load, tx_fin;
   logic [TW-1:0] to_cnt;
   logic [3:0]    tx_bit;
   logic [9:0]    tx_shift;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_st    <= R_IDLE;
         rx_cnt   <= '0;
         rx_bits  <= '0;
         rx_shift <= '0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         case (rx_st)
            R_IDLE: if (rx_prev && !rx_sync) begin
               rx_st  <= R_START;
               rx_cnt <= '0;
            end
            R_START: if (rx_cnt == HALF_END) begin
               rx_cnt <= '0;
               rx_st  <= rx_sync ? R_IDLE : R_DATA;
            end else rx_cnt <= rx_cnt + 1'b1;
            R_DATA: if (rx_cnt == BIT_END) begin
               rx_cnt   <= '0;
               rx_shift <= {rx_sync, rx_shift[7:1]};
               rx_bits  <= rx_bits + 3'd1;
               if (rx_bits == 3'd7) rx_st <= R_STOP;
            end else rx_cnt <= rx_cnt + 1'b1;
            default: if (rx_cnt == BIT_END) begin
               rx_cnt <= '0;
               rx_st  <= R_IDLE;
            end else rx_cnt <= rx_cnt + 1'b1;
         endcase
      end
   end

   // a low stop sample simply drops the byte here, so framing errors never reach the parser
   assign rx_done = rx_st == R_STOP && rx_cnt == BIT_END && rx_sync;
   assign waiting = (state == GET_ADDR || state == GET_DATA) && rx_st == R_IDLE;
   assign to_hit  = waiting && to_cnt == TO_END;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else state <= next;
   end

   always_comb begin
      next     = state;
      mem_w_en = 1'b0;
      mem_r_en = 1'b0;
      case (state)
         IDLE:     if (rx_done) next = (rx_shift == 8'h57 || rx_shift == 8'h52) ? GET_ADDR : RESPOND;
         GET_ADDR: next = rx_done ? (op_w ? GET_DATA : EXEC_R) : to_hit ? IDLE : GET_ADDR;
         GET_DATA: next = rx_done ? EXEC_W : to_hit ? IDLE : GET_DATA;
         EXEC_W: begin
            mem_w_en = 1'b1;
            next     = RESPOND;
         end
         EXEC_R: begin
            mem_r_en = 1'b1;
            next     = RESPOND;
         end
         RESPOND:  if (tx_fin) next = IDLE;
         default:  next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_w       <= 1'b0;
         resp       <= '0;
         mem_addr   <= '0;
         mem_w_data <= '0;
         to_cnt     <= '0;
      end else begin
         to_cnt <= (waiting && !to_hit) ? to_cnt + 1'b1 : '0;
         if (state == IDLE && rx_done) begin
            op_w <= rx_shift == 8'h57;
            resp <= 8'h3F;
         end
         if (state == GET_ADDR && rx_done) mem_addr <= rx_shift;
         if (state == GET_DATA && rx_done) mem_w_data <= rx_shift;
         if (mem_w_en) resp <= 8'h4B;
         if (mem_r_en) resp <= mem_r_data;
      end
   end

   // the frame is loaded on the first RESPOND cycle, so tx drops one cycle after entry
   assign tx_load = state == RESPOND && !tx_active;
   assign tx_fin  = tx_active && tx_cnt == BIT_END && tx_bit == 4'd9;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_active <= 1'b0;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= '0;
      end else if (tx_load) begin
         tx_active <= 1'b1;
         tx_cnt    <= '0;
         tx_bit    <= '0;
         tx_shift  <= {1'b1, resp, 1'b0};
      end else if (tx_active) begin
         if (tx_cnt == BIT_END) begin
            tx_cnt    <= '0;
            tx_shift  <= {1'b1, tx_shift[9:1]};
            tx_bit    <= tx_fin ? 4'd0 : tx_bit + 4'd1;
            tx_active <= !tx_fin;
         end else tx_cnt <= tx_cnt + 1'b1;
      end
   end

   assign tx   = tx_active ? tx_shift[0] : 1'b1;
   assign busy = state != IDLE || tx_active;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: drives UART commands into uart_mem_bridge, decodes its tx line and
// compares strobes and responses against a command-level model of the protocol.
module tb_uart_mem_bridge;
   localparam int C = 16;

   logic       clock = 1'b0;
   logic       reset_n, rx;
   logic       tx, mem_w_en, mem_r_en, busy;
   logic [7:0] mem_addr, mem_w_data, mem_r_data;

   logic [7:0]  tb_mem    [256];
   logic [7:0]  model_mem [256];
   logic [7:0]  rxq [$];
   logic [15:0] wq  [$];
   logic [7:0]  rq  [$];
   int n_checks = 0, n_fail = 0, cyc = 0, w_cyc = 0, both = 0;
   int tx_falls = 0, rst_cnt = 0, last_start = 0, tx_bad = 0;

   always #5 clock = ~clock;

   assign mem_r_data = tb_mem[mem_addr];

   uart_mem_bridge dut (
      .clock(clock), .reset_n(reset_n), .rx(rx), .tx(tx),
      .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
      .mem_r_en(mem_r_en), .mem_r_data(mem_r_data), .busy(busy)
   );

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         if (mem_w_en === 1'b1) begin
            wq.push_back({mem_addr, mem_w_data});
            tb_mem[mem_addr] <= mem_w_data;
            w_cyc <= cyc;
         end
         if (mem_r_en === 1'b1) rq.push_back(mem_addr);
         if (mem_w_en === 1'b1 && mem_r_en === 1'b1) both <= both + 1;
      end
   end

   always @(negedge tx) tx_falls <= tx_falls + 1;
   always @(negedge reset_n) rst_cnt <= rst_cnt + 1;

   initial begin : tx_decoder
      logic [7:0] b;
      logic ok;
      int r0;
      forever begin
         @(negedge tx);
         r0 = rst_cnt;
         repeat (C / 2) @(negedge clock);
         ok = (tx === 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (C) @(negedge clock);
            b[i] = tx;
         end
         repeat (C) @(negedge clock);
         ok = ok && (tx === 1'b1);
         if (r0 == rst_cnt && reset_n === 1'b1) begin
            rxq.push_back(b);
            if (!ok) tx_bad++;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      @(negedge clock);
      rx = 1'b0;
      last_start = cyc;
      repeat (C) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (C) @(negedge clock);
      end
      rx = stop_bit;
      repeat (C) @(negedge clock);
      rx = 1'b1;
   endtask

   task automatic wait_idle(input int max_cycles);
      int k = 0;
      @(negedge clock);
      while (busy !== 1'b0 && k < max_cycles) begin
         @(negedge clock);
         k++;
      end
      if (busy !== 1'b0) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, max_cycles);
      end
   endtask

   task automatic clear_logs();
      rxq.delete();
      wq.delete();
      rq.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i);
      repeat (4) @(negedge clock);
      n_checks++;
      if ({tx, busy, mem_w_en, mem_r_en, mem_addr, mem_w_data} !== {4'b1000, 16'h0000}) begin
         n_fail++;
         $display("FAIL reset_state: got tx/busy/we/re=%b%b%b%b addr=%h wdata=%h, required 1000 00 00",
                  tx, busy, mem_w_en, mem_r_en, mem_addr, mem_w_data);
      end
      reset_n = 1'b1;
      repeat (20) @(negedge clock);
      n_checks++;
      if ({tx, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL idle_after_reset: got tx=%b busy=%b, required tx=1 busy=0", tx, busy);
      end
   endtask

   task automatic test_write();
      clear_logs();
      send_byte(8'h57, 1'b1);
      send_byte(8'h10, 1'b1);
      send_byte(8'hA5, 1'b1);
      wait_idle(4000);
      n_checks++;
      if (wq.size() != 1 || wq[0] !== 16'h10A5 || rq.size() != 0) begin
         n_fail++;
         $display("FAIL write_strobe: got %0d writes (first %h) %0d reads, required one write 10A5",
                  wq.size(), wq.size() > 0 ? wq[0] : 16'hxxxx, rq.size());
      end
      n_checks++;
      if (w_cyc - last_start < 152 || w_cyc - last_start > 160) begin
         n_fail++;
         $display("FAIL write_latency: got %0d cycles from data start bit, required 152..160",
                  w_cyc - last_start);
      end
      n_checks++;
      if (rxq.size() != 1 || rxq[0] !== 8'h4B) begin
         n_fail++;
         $display("FAIL write_resp: got %0d bytes (first %h), required one byte 4B",
                  rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
      end
      repeat (50) @(negedge clock);
      n_checks++;
      if ({mem_addr, mem_w_data} !== 16'h10A5) begin
         n_fail++;
         $display("FAIL addr_data_hold: got %h%h, required 10A5", mem_addr, mem_w_data);
      end
   endtask

   task automatic test_read();
      clear_logs();
      tb_mem[8'h10] <= 8'h3C;
      send_byte(8'h52, 1'b1);
      send_byte(8'h10, 1'b1);
      wait_idle(4000);
      n_checks++;
      if (rq.size() != 1 || rq[0] !== 8'h10 || wq.size() != 0) begin
         n_fail++;
         $display("FAIL read_strobe: got %0d reads (first %h) %0d writes, required one read at 10",
                  rq.size(), rq.size() > 0 ? rq[0] : 8'hxx, wq.size());
      end
      n_checks++;
      if (rxq.size() != 1 || rxq[0] !== 8'h3C) begin
         n_fail++;
         $display("FAIL read_resp: got %0d bytes (first %h), required one byte 3C",
                  rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
      end
   endtask

   task automatic test_unknown();
      clear_logs();
      send_byte(8'h00, 1'b1);
      wait_idle(4000);
      n_checks++;
      if (rxq.size() != 1 || rxq[0] !== 8'h3F || wq.size() + rq.size() != 0) begin
         n_fail++;
         $display("FAIL unknown_cmd: got %0d bytes (first %h) %0d strobes, required one byte 3F, no strobe",
                  rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx, wq.size() + rq.size());
      end
   endtask

   task automatic test_timeout();
      clear_logs();
      send_byte(8'h57, 1'b1);
      send_byte(8'h21, 1'b1);
      repeat (4000) @(negedge clock);
      send_byte(8'h66, 1'b1);
      wait_idle(4000);
      n_checks++;
      if (wq.size() != 1 || wq[0] !== 16'h2166 || rxq.size() != 1 || rxq[0] !== 8'h4B) begin
         n_fail++;
         $display("FAIL below_timeout: got %0d writes (first %h) %0d bytes, required write 2166 and 4B",
                  wq.size(), wq.size() > 0 ? wq[0] : 16'hxxxx, rxq.size());
      end
      clear_logs();
      send_byte(8'h57, 1'b1);
      send_byte(8'h20, 1'b1);
      repeat (4100) @(negedge clock);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_abort: got busy=%b after idle gap, required 0", busy);
      end
      send_byte(8'h52, 1'b1);
      send_byte(8'h01, 1'b1);
      wait_idle(4000);
      n_checks++;
      if (wq.size() != 0 || rq.size() != 1 || rq[0] !== 8'h01 || rxq.size() != 1) begin
         n_fail++;
         $display("FAIL timeout_then_read: got %0d writes %0d reads (first %h) %0d bytes, required 0/1(01)/1",
                  wq.size(), rq.size(), rq.size() > 0 ? rq[0] : 8'hxx, rxq.size());
      end
   endtask

   task automatic test_framing_glitch();
      clear_logs();
      send_byte(8'h57, 1'b0);
      @(negedge clock);
      rx = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      repeat (300) @(negedge clock);
      n_checks++;
      if (rxq.size() != 0 || busy !== 1'b0 || wq.size() + rq.size() != 0) begin
         n_fail++;
         $display("FAIL framing_glitch: got %0d bytes busy=%b %0d strobes, required 0 bytes busy=0 no strobe",
                  rxq.size(), busy, wq.size() + rq.size());
      end
      send_byte(8'h00, 1'b1);
      wait_idle(4000);
      n_checks++;
      if (rxq.size() != 1 || rxq[0] !== 8'h3F) begin
         n_fail++;
         $display("FAIL idle_after_framing: got %0d bytes (first %h), required one byte 3F",
                  rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         tb_mem[i] <= v;
         model_mem[i] = v;
      end
      for (int i = 0; i < 12; i++) begin
         int kind;
         logic [7:0] a, d, o, er;
         kind = $urandom_range(0, 2);
         a = 8'($urandom_range(0, 7));
         d = 8'($urandom);
         do o = 8'($urandom); while (o == 8'h57 || o == 8'h52);
         clear_logs();
         if (kind == 0) begin
            er = 8'h4B;
            model_mem[a] = d;
            send_byte(8'h57, 1'b1);
            send_byte(a, 1'b1);
            send_byte(d, 1'b1);
         end else if (kind == 1) begin
            er = model_mem[a];
            send_byte(8'h52, 1'b1);
            send_byte(a, 1'b1);
         end else begin
            er = 8'h3F;
            send_byte(o, 1'b1);
         end
         wait_idle(4000);
         n_checks++;
         if (rxq.size() != 1 || rxq[0] !== er) begin
            n_fail++;
            $display("FAIL rand_resp[%0d]: kind %0d got %0d bytes (first %h), required one byte %h",
                     i, kind, rxq.size(), rxq.size() > 0 ? rxq[0] : 8'hxx, er);
         end
         n_checks++;
         if (wq.size() != int'(kind == 0) || rq.size() != int'(kind == 1) ||
             (kind == 0 && wq[0] !== {a, d}) || (kind == 1 && rq[0] !== a)) begin
            n_fail++;
            $display("FAIL rand_strobe[%0d]: kind %0d got %0d writes %0d reads, required addr %h data %h",
                     i, kind, wq.size(), rq.size(), a, d);
         end
      end
   endtask

   task automatic test_reset_mid_response();
      int k, falls;
      clear_logs();
      send_byte(8'h57, 1'b1);
      send_byte(8'h30, 1'b1);
      send_byte(8'h77, 1'b1);
      k = 0;
      while (tx !== 1'b0 && k < 3000) begin
         @(negedge clock);
         k++;
      end
      n_checks++;
      if (tx !== 1'b0) begin
         n_fail++;
         $display("FAIL resp_start: got tx=%b after %0d cycles, required a start bit", tx, k);
      end
      repeat (5 * C) @(negedge clock);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({tx, busy, mem_w_en, mem_r_en, mem_addr, mem_w_data} !== {4'b1000, 16'h0000}) begin
         n_fail++;
         $display("FAIL async_reset: got tx/busy/we/re=%b%b%b%b addr=%h wdata=%h, required 1000 00 00",
                  tx, busy, mem_w_en, mem_r_en, mem_addr, mem_w_data);
      end
      falls = tx_falls;
      clear_logs();
      repeat (10) @(negedge clock);
      reset_n = 1'b1;
      repeat (3000) @(negedge clock);
      n_checks++;
      if (tx_falls != falls || rxq.size() != 0 || wq.size() + rq.size() != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset_quiet: got %0d tx falls %0d bytes %0d strobes busy=%b, required 0 0 0 0",
                  tx_falls - falls, rxq.size(), wq.size() + rq.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_unknown();
      test_timeout();
      test_framing_glitch();
      test_random();
      test_reset_mid_response();
      n_checks++;
      if (both != 0 || tx_bad != 0) begin
         n_fail++;
         $display("FAIL global: got %0d overlapping strobes %0d bad tx frames, required 0 and 0", both, tx_bad);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
